// File: rtl/oam_update_sched_pkg.sv
// OAM update scheduler shared types and PPU/VGA geometry constants.
// No logic; pure declarations.
// No flow control.
package oam_update_sched_pkg;

    localparam int OAM_ADDR_W = 6;
    localparam int OAM_DATA_W = 32;

    // Field offsets inside a 32-bit OAM entry {pal, tile, y, x}
    localparam int OAM_X_LSB    = 0;
    localparam int OAM_Y_LSB    = 8;
    localparam int OAM_TILE_LSB = 16;
    localparam int OAM_PAL_LSB  = 24;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_TOTAL   = 525;

    localparam int REQ_W = OAM_ADDR_W + OAM_DATA_W;

    typedef struct packed {
        logic [OAM_ADDR_W-1:0] addr;
        logic [OAM_DATA_W-1:0] data;
    } oam_req_t;

    // Scheduler FSM encoding
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Assemble an OAM entry from its four byte fields
    function automatic logic [OAM_DATA_W-1:0] oam_pack(input logic [7:0] pal, input logic [7:0] tile,
                                                       input logic [7:0] y, input logic [7:0] x);
        logic [OAM_DATA_W-1:0] e;
        e = '0;
        e[OAM_PAL_LSB  +: 8] = pal;
        e[OAM_TILE_LSB +: 8] = tile;
        e[OAM_Y_LSB    +: 8] = y;
        e[OAM_X_LSB    +: 8] = x;
        return e;
    endfunction

endpackage

// File: rtl/oam_update_sched_if.sv
// One requester's OAM write request channel (index + entry).
// Combinational wires only.
// valid/ready: transfer happens on a clock edge with both high.
interface oam_update_sched_if;
    import oam_update_sched_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [OAM_ADDR_W-1:0] addr;
    logic [OAM_DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/oam_update_sched_req_fifo.sv
// Synchronous FIFO holding accepted OAM requests in arrival order.
// Head visible combinationally; push/pop take effect at the clock edge.
// Push ignored when full, pop ignored when empty; caller gates both.
module oam_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 38,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since count guards every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/oam_update_sched.sv
// Round-robin arbitration of two OAM writers into a FIFO, drained to the PPU only in vblank.
// First write two edges after vCount reaches VBLANK_LINE; one write per clock after that.
// Readies drop only when the FIFO is full (registered count) or the other requester holds priority.
module oam_update_sched
    import oam_update_sched_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int VBLANK_LINE    = VGA_V_VISIBLE,
    parameter int MAX_PER_VBLANK = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            vCount,
    oam_update_sched_if.slave     req0,
    oam_update_sched_if.slave     req1,
    output logic [OAM_ADDR_W-1:0] oam_addr,
    output logic [OAM_DATA_W-1:0] oam_data,
    output logic                  oam_write,
    output logic [CW-1:0]         fifo_count,
    output logic                  frame_sync
);

    logic       vblank, vblank_q, vblank_rise;
    logic       last_grant;          // 1: req1 was granted last, so req0 wins a tie
    logic       full, empty;
    logic       ready0, ready1, acc0, acc1, push, pop;
    logic [1:0] state;
    logic [6:0] budget, budget_inc;
    oam_req_t   push_req, head;

    assign vblank      = (vCount >= 10'(VBLANK_LINE));
    assign vblank_rise = vblank & ~vblank_q;

    // A requester is refused only for a full FIFO or when the other one is valid and owns the tie
    assign ready0     = ~full & ~(req1.valid & ~last_grant);
    assign ready1     = ~full & ~(req0.valid & last_grant);
    assign req0.ready = ready0;
    assign req1.ready = ready1;
    assign acc0       = req0.valid & ready0;
    assign acc1       = req1.valid & ready1;
    assign push       = acc0 | acc1;

    assign pop        = (state == ST_DRAIN) & vblank & ~empty;
    assign budget_inc = budget + 7'd1;

    // Select the accepted requester's payload for the FIFO
    always_comb begin
        push_req = '0;
        if (acc0) begin
            push_req.addr = req0.addr;
            push_req.data = req0.data;
        end else begin
            push_req.addr = req1.addr;
            push_req.data = req1.data;
        end
    end

    oam_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .count (fifo_count),
        .empty (empty),
        .full  (full)
    );

    // Round-robin memory and vblank edge detector; vblank_q resets high so a release mid-blank is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            vblank_q   <= 1'b1;
            frame_sync <= 1'b0;
        end else begin
            if (acc0)      last_grant <= 1'b0;
            else if (acc1) last_grant <= 1'b1;
            vblank_q   <= vblank;
            frame_sync <= vblank_rise;
        end
    end

    // Drain window FSM: open at vblank start, close on budget exhaustion or end of blank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_ACTIVE;
            budget <= '0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (vblank_rise) begin
                        state  <= ST_DRAIN;
                        budget <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!vblank) begin
                        state <= ST_ACTIVE;
                    end else if (pop) begin
                        budget <= budget_inc;
                        if (budget_inc == 7'(MAX_PER_VBLANK)) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!vblank) state <= ST_ACTIVE;
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

    // PPU write port: strobe for exactly the popped cycle, address/data hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oam_write <= 1'b0;
            oam_addr  <= '0;
            oam_data  <= '0;
        end else begin
            oam_write <= pop;
            if (pop) begin
                oam_addr <= head.addr;
                oam_data <= head.data;
            end
        end
    end

endmodule

// File: doc/oam_update_sched.md
# oam_update_sched

Schedules sprite-attribute writes into the PPU's OAM port so that OAM is only modified during vertical blank. Two requesters (e.g. game-logic CPU and a sprite-animation engine) submit {OAM index, 32-bit entry} via valid/ready. The block arbitrates round-robin, buffers requests in a small FIFO and drains them to the PPU's cpu_oam_addr / cpu_oam_data / cpu_write inputs once vCount from vga_controller enters the blanking region. It sits between the requesters and the ppu instance, on the same 25 MHz pixel clock.

## Interface
- DEPTH, 8, FIFO entries (power of two, ≥2)
- VBLANK_LINE, 480, first vCount value treated as vertical blank
- MAX_PER_VBLANK, 64, maximum OAM writes issued per blanking interval (1..127)
- clk  in  1  pixel clock (clock_25)
- reset  in  1  asynchronous, active-low reset
- vCount  in  10  current line from vga_controller
- req0_valid / req1_valid  in  1  request present
- req0_addr / req1_addr  in  6  OAM sprite index
- req0_data / req1_data  in  32  entry {pal[31:24], tile[23:16], y[15:8], x[7:0]}
- req0_ready / req1_ready  out  1  request accepted at this edge if valid
- oam_addr  out  6  to ppu cpu_oam_addr
- oam_data  out  32  to ppu cpu_oam_data
- oam_write  out  1  one-cycle write strobe to ppu cpu_write
- fifo_count  out  $clog2(DEPTH+1)  occupied entries
- frame_sync  out  1  one-cycle pulse marking start of vertical blank

## Operation
- vblank = (vCount >= VBLANK_LINE); vblank_q is its registered copy; vblank_rise = vblank & ~vblank_q.
- Arbitration: push allowed only when fifo_count < DEPTH (registered count; a pop in the same cycle does not free space for a push). One valid → that requester ready. Both valid → requester not granted last wins; last_grant updates on every accept. Not full → readies depend only on valids and last_grant.
- FIFO preserves acceptance order; no coalescing of repeated indices.
- FSM states:
  - ACTIVE: no pops. vblank_rise → DRAIN, budget cleared.
  - DRAIN: if ~vblank → ACTIVE (no pop this edge). Else if FIFO non-empty → pop head, load oam_addr/oam_data, oam_write=1, budget+1; if new budget == MAX_PER_VBLANK → DONE. Empty FIFO → stay in DRAIN; late pushes drain in the same vblank.
  - DONE: no pops; ~vblank → ACTIVE.
- oam_write is 0 on every edge without a pop; oam_addr/oam_data hold last written values.
- frame_sync registered from vblank_rise.

## Timing
- Reset (async): state ACTIVE, FIFO empty, fifo_count 0, last_grant=1 (req0 wins first tie), budget 0, oam_write 0, oam_addr 0, oam_data 0, frame_sync 0, vblank_q 1.
- vblank_q resets to 1: release mid-blank produces no drain until the next real vblank.
- vCount becomes VBLANK_LINE at edge T → FSM enters DRAIN and frame_sync high after edge T+1 → first pop at T+2, oam_write high for cycle after T+2. Back-to-back pops: one write per clock.
- Push accepted at edge E while in DRAIN with empty FIFO → oam_write high in cycle after E+1.
- vCount wrap to 0 at edge W → pops stop at edge W+1; writes issued up to edge W are complete, rest stay queued.
- Full FIFO with simultaneous pop: ready stays 0 that cycle; fifo_count drops by 1.
- Reset mid-drain: oam_write drops immediately; queued entries discarded.

## Structure
- Shared ppu_pkg: OAM_ADDR_W=6, OAM_DATA_W=32, OAM field offsets, VGA_V_VISIBLE=480, VGA_V_TOTAL=525.
- One sub-module: oam_req_fifo (synchronous FIFO, DEPTH×38 bits, push/pop/count/empty/full, async active-low reset). Arbiter and FSM stay in oam_update_sched.

## Test plan
- Push req0 {addr 0, data 0x01_05_10_64} at vCount=100 → no oam_write during active lines; oam_write with addr 0 / data 0x01051064 in cycle after T+2 where vCount hits 480; frame_sync pulses once.
- Both valid continuously from reset at vCount=0 → accept order req0,req1,req0,…; readies 0 after 8 accepts, fifo_count=8; drain writes in that order.
- MAX_PER_VBLANK=4, 8 queued → exactly 4 writes in first vblank, state DONE, fifo_count=4; remaining 4 in next vblank.
- 8 queued, vCount forced to 0 after 3rd write → no further writes, fifo_count=5; 5 writes next vblank, order preserved.
- Reset low during drain at vCount=490 → oam_write 0 asynchronously, fifo_count 0; release at 495, push 1 entry → no write until next frame's line 480.
- Push during DRAIN with empty FIFO at vCount=500 → single write in cycle after E+1; readies stay 1.
